// File: rtl/multibyte_add_seq_pkg.sv
// Shared constants for the byte-serial wide adder: controller state encoding and slice width.
package multibyte_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multibyte_add_seq_hybridadder8.sv
// 8-bit hybrid adder slice: two 4-bit carry-lookahead groups with the group carry rippled between them.
module hybridadder8_struct
    import multibyte_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              c_i,
    output logic [BYTE_W-1:0] s_o,
    output logic              c_o
);

    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] g;
    logic [BYTE_W:0]   c;

    assign p    = a_i ^ b_i;
    assign g    = a_i & b_i;
    assign c[0] = c_i;

    for (genvar k = 0; k < BYTE_W / 4; k++) begin : g_cla
        localparam int B = 4 * k;
        // Every carry in a group looks back only to the group carry-in c[B].
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end

    assign s_o = p ^ c[BYTE_W-1:0];
    assign c_o = c[BYTE_W];

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial W-bit adder reusing one 8-bit slice over NBYTES cycles, LSB byte first.
// Define MULTIBYTE_SUB_EN to add the Sub port (A-B via inverted B and forced carry-in).
module multibyte_add_seq
    import multibyte_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [BYTE_W*NBYTES-1:0] Xi,
    input  logic [BYTE_W*NBYTES-1:0] Yi,
    input  logic                     C0,
`ifdef MULTIBYTE_SUB_EN
    input  logic                     Sub,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] Si,
    output logic                     Cout,
    output logic                     Ovf
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            sub_q;
    logic [W-1:0]    si_q;
    logic            cout_q;
    logic            ovf_q;
    logic            busy_q;
    logic            done_q;

    logic              sub_in;
    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    logic [BYTE_W-1:0] s_byte;
    logic              c_slice;
    logic              b_msb_eff;

`ifdef MULTIBYTE_SUB_EN
    assign sub_in = Sub;
`else
    assign sub_in = 1'b0;
`endif

    assign a_byte    = a_q[idx_q*BYTE_W +: BYTE_W];
    assign b_byte    = b_q[idx_q*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_q}};
    assign b_msb_eff = b_q[W-1] ^ sub_q;

    hybridadder8_struct u_slice (
        .a_i (a_byte),
        .b_i (b_byte),
        .c_i (carry_q),
        .s_o (s_byte),
        .c_o (c_slice)
    );

    // NOTE: the operand store is reset along with the control state so an aborted
    // operation leaves nothing behind; all state here updates with <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            si_q    <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= Xi;
                        b_q     <= Yi;
                        sub_q   <= sub_in;
                        carry_q <= sub_in | C0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    si_q[idx_q*BYTE_W +: BYTE_W] <= s_byte;
                    carry_q <= c_slice;
                    if (idx_q == LAST_IDX) begin
                        // Index parks on the last byte so it never leaves 0..NBYTES-1.
                        cout_q  <= c_slice;
                        ovf_q   <= (a_q[W-1] == b_msb_eff) && (s_byte[BYTE_W-1] != a_q[W-1]);
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Si   = si_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule
